// File: rtl/vfu_result_buffer.sv
// FWFT result FIFO behind the VFU: 1-cycle write-to-head, no backpressure upstream, writes into a full FIFO are dropped and flagged.
// Optional per-lane FP16 running maximum, built only with VFU_RESULT_BUFFER_MAX_TRACK_EN defined.
module vfu_result_buffer #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*16-1:0]        in_vect_flat,
  input  logic                   in_tvalid,
  output logic [N*16-1:0]        out_vect_flat,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_max,
  output logic [N*16-1:0]        max_vect_flat
);
  localparam int W  = N * 16;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  logic          pop, wr;

  // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
  assign pop = !empty_q && out_tready;
  assign wr  = in_tvalid && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr) begin
      count_d = count_q - CW'(1);
    end
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (in_tvalid && !wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem_q[wr_ptr_q] <= in_vect_flat;
    end
  end

  assign out_tvalid    = !empty_q;
  assign out_vect_flat = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow      = overflow_q;

`ifdef VFU_RESULT_BUFFER_MAX_TRACK_EN
  logic [W-1:0] max_q, max_d;

  // Sign-magnitude ordering; differing signs means the positive one wins, which ranks +0 above -0.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  function automatic logic [15:0] lane_next(input logic [15:0] cur, input logic [15:0] inc,
                                            input logic clr, input logic we);
    logic [15:0] base;
    logic        inc_nan;
    base    = clr ? NEG_INF : cur;
    inc_nan = (inc[14:10] == 5'h1F) && (inc[9:0] != '0);
    if (we && !inc_nan && fp16_gt(inc, base)) return inc;
    return base;
  endfunction

  always_comb begin
    max_d = max_q;
    for (int i = 0; i < N; i++) begin
      max_d[i*16 +: 16] = lane_next(max_q[i*16 +: 16], in_vect_flat[i*16 +: 16], clr_max, wr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= {N{NEG_INF}};
    end else begin
      max_q <= max_d;
    end
  end

  assign max_vect_flat = max_q;
`else
  logic unused_clr_max;
  assign unused_clr_max = clr_max;
  assign max_vect_flat  = {N{NEG_INF}};
`endif

endmodule

// File: tb/tb_vfu_result_buffer.sv
// Randomized and directed bench for vfu_result_buffer against a queue-based model with real-valued FP16 maxima.
module tb_vfu_result_buffer;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int W     = N * 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef VFU_RESULT_BUFFER_MAX_TRACK_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_vect_flat = '0;
  logic          in_tvalid = 1'b0;
  logic [W-1:0]  out_vect_flat;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic [CW-1:0] count;
  logic          full, empty, overflow;
  logic          clr_max = 1'b0;
  logic [W-1:0]  max_vect_flat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  mq[$];
  bit            m_ovf;
  logic [15:0]   m_max[N];

  vfu_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vect_flat(in_vect_flat), .in_tvalid(in_tvalid),
    .out_vect_flat(out_vect_flat), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_max(clr_max), .max_vect_flat(max_vect_flat)
  );

  always #5 clk = ~clk;

  // FP16 as a real number; infinities mapped beyond the finite range.
  function automatic real fp16_val(input logic [15:0] h);
    real mag;
    int  e;
    e = int'(h[14:10]);
    if (e == 31)     mag = 1.0e10;
    else if (e == 0) mag = real'(h[9:0]) * (2.0 ** -24);
    else             mag = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -mag : mag;
  endfunction

  function automatic bit fp16_is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic bit fp16_greater(input logic [15:0] a, input logic [15:0] b);
    real va, vb;
    va = fp16_val(a);
    vb = fp16_val(b);
    if (va != vb) return va > vb;
    return (a[15] == 1'b0) && (b[15] == 1'b1);
  endfunction

  function automatic logic [W-1:0] model_max_flat();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = m_max[i];
    return r;
  endfunction

  function automatic logic [W-1:0] model_head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic model_edge(input logic iv, input logic [W-1:0] v, input logic rdy,
                            input logic clr, input logic r);
    bit pop, acc;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < N; i++) m_max[i] = 16'hFC00;
    end else begin
      pop = (mq.size() > 0) && rdy;
      acc = iv && ((mq.size() < DEPTH) || pop);
      if (iv && !acc) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(v);
      if (MAXEN) begin
        if (clr) for (int i = 0; i < N; i++) m_max[i] = 16'hFC00;
        if (acc) begin
          for (int i = 0; i < N; i++) begin
            if (!fp16_is_nan(v[i*16 +: 16]) && fp16_greater(v[i*16 +: 16], m_max[i]))
              m_max[i] = v[i*16 +: 16];
          end
        end
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] v, input logic rdy,
                       input logic clr, input logic r);
    in_tvalid    = iv;
    in_vect_flat = v;
    out_tready   = rdy;
    clr_max      = clr;
    rst          = r;
    @(posedge clk);
    model_edge(iv, v, rdy, clr, r);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, '1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", out_tvalid); end
    n_checks++; if (out_vect_flat !== '0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_vect_flat); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (max_vect_flat !== {N{16'hFC00}}) begin n_fail++; $display("FAIL reset_max got=%h exp=%h", max_vect_flat, {N{16'hFC00}}); end
  endtask

  task automatic test_single();
    logic [W-1:0] v;
    v = 64'h4000_3E00_3C00_3800;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== '0 || empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop count=%0d empty=%b exp 0/1", count, empty); end
    drive(1'b1, v, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid got=%b exp=1", out_tvalid); end
    n_checks++; if (out_vect_flat !== v) begin n_fail++; $display("FAIL single_out got=%h exp=%h", out_vect_flat, v); end
    n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count got=%0d exp=1", count); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] vecs[9];
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      vecs[k] = {$urandom, $urandom};
      drive(1'b1, vecs[k], 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
    n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (out_vect_flat !== vecs[k] || out_tvalid !== 1'b1) begin n_fail++; $display("FAIL fill_pop%0d got=%h exp=%h", k, out_vect_flat, vecs[k]); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++; if (empty !== 1'b1 || out_tvalid !== 1'b0) begin n_fail++; $display("FAIL fill_drained empty=%b tvalid=%b exp 1/0", empty, out_tvalid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_wr_pop();
    logic [W-1:0] vecs[8];
    logic [W-1:0] nv;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vecs[k] = {$urandom, $urandom};
      drive(1'b1, vecs[k], 1'b0, 1'b0, 1'b0);
    end
    nv = {$urandom, $urandom};
    drive(1'b1, nv, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin n_fail++; $display("FAIL fullwp_count got=%0d full=%b exp=%0d/1", count, full, DEPTH); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullwp_ovf got=%b exp=0", overflow); end
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] e;
      e = (k < 7) ? vecs[k+1] : nv;
      n_checks++; if (out_vect_flat !== e) begin n_fail++; $display("FAIL fullwp_pop%0d got=%h exp=%h", k, out_vect_flat, e); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullwp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_max();
    logic [15:0] seq[4];
    logic [W-1:0] v;
    logic [15:0] e;
    seq = '{16'h3800, 16'hC400, 16'h7E00, 16'h3C00};
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      v = {$urandom, $urandom};
      v[15:0] = seq[k];
      drive(1'b1, v, 1'b1, 1'b0, 1'b0);
    end
    e = MAXEN ? 16'h3C00 : 16'hFC00;
    n_checks++; if (max_vect_flat[15:0] !== e) begin n_fail++; $display("FAIL max_lane0 got=%h exp=%h", max_vect_flat[15:0], e); end
    n_checks++; if (max_vect_flat !== model_max_flat()) begin n_fail++; $display("FAIL max_lanes got=%h exp=%h", max_vect_flat, model_max_flat()); end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (max_vect_flat !== {N{16'hFC00}}) begin n_fail++; $display("FAIL max_clr got=%h exp=%h", max_vect_flat, {N{16'hFC00}}); end
    drive(1'b1, {N{16'h8000}}, 1'b1, 1'b0, 1'b0);
    e = MAXEN ? 16'h8000 : 16'hFC00;
    n_checks++; if (max_vect_flat !== {N{e}}) begin n_fail++; $display("FAIL max_negzero got=%h exp=%h", max_vect_flat, {N{e}}); end
    drive(1'b1, {N{16'h0000}}, 1'b1, 1'b0, 1'b0);
    e = MAXEN ? 16'h0000 : 16'hFC00;
    n_checks++; if (max_vect_flat !== {N{e}}) begin n_fail++; $display("FAIL max_poszero got=%h exp=%h", max_vect_flat, {N{e}}); end
  endtask

  task automatic test_clr_same_edge();
    logic [15:0] e;
    drive(1'b1, {N{16'h7800}}, 1'b1, 1'b0, 1'b0);
    drive(1'b1, {N{16'h4200}}, 1'b1, 1'b1, 1'b0);
    e = MAXEN ? 16'h4200 : 16'hFC00;
    n_checks++; if (max_vect_flat !== {N{e}}) begin n_fail++; $display("FAIL clr_wr got=%h exp=%h", max_vect_flat, {N{e}}); end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (max_vect_flat !== {N{16'hFC00}}) begin n_fail++; $display("FAIL clr_only got=%h exp=%h", max_vect_flat, {N{16'hFC00}}); end
    drive(1'b1, {N{16'h4400}}, 1'b1, 1'b0, 1'b0);
    drive(1'b1, {N{16'h7E01}}, 1'b1, 1'b1, 1'b0);
    n_checks++; if (max_vect_flat !== {N{16'hFC00}}) begin n_fail++; $display("FAIL clr_nan got=%h exp=%h", max_vect_flat, {N{16'hFC00}}); end
  endtask

  task automatic test_random_traffic();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] v;
      logic iv, rdy, clr;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) v[31:16] = 16'hFE00;
      if ($urandom_range(0, 7) == 0) v[15:0] = 16'h0000 | {$urandom_range(0, 1) == 1, 15'd0};
      iv  = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 99) < ((c % 200) < 100 ? 25 : 75);
      clr = $urandom_range(0, 31) == 0;
      drive(iv, v, rdy, clr, 1'b0);
      n_checks++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
      n_checks++; if (out_tvalid !== (mq.size() != 0) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_flags c=%0d tvalid=%b empty=%b full=%b size=%0d", c, out_tvalid, empty, full, mq.size()); end
      n_checks++; if (out_vect_flat !== model_head()) begin n_fail++; $display("FAIL rnd_out c=%0d got=%h exp=%h", c, out_vect_flat, model_head()); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
      n_checks++; if (max_vect_flat !== model_max_flat()) begin n_fail++; $display("FAIL rnd_max c=%0d got=%h exp=%h", c, max_vect_flat, model_max_flat()); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== CW'(5) || overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre count=%0d ovf=%b exp=5/1", count, overflow); end
    drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== '0 || empty !== 1'b1 || out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst count=%0d empty=%b tvalid=%b exp 0/1/0", count, empty, out_tvalid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
    n_checks++; if (max_vect_flat !== {N{16'hFC00}}) begin n_fail++; $display("FAIL mid_max got=%h exp=%h", max_vect_flat, {N{16'hFC00}}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_wr_pop();
    test_max();
    test_clr_same_edge();
    test_random_traffic();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vfu_result_buffer.md
VFU_RESULT_BUFFER -- requirements
Module: vfu_result_buffer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the FP16 lane count and matching the upstream VFU.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the FIFO depth in vectors; it is a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_vect_flat, input, N*16 bits: VFU result vector; lane i occupies bits [i*16 +: 16].
REQ-006 The block SHALL have port in_tvalid, input, 1 bit: the VFU out_tvalid; there is no backpressure toward the VFU.
REQ-007 The block SHALL have port out_vect_flat, output, N*16 bits: head-of-FIFO vector.
REQ-008 The block SHALL have port out_tvalid, output, 1 bit: the head vector is valid.
REQ-009 The block SHALL have port out_tready, input, 1 bit: the downstream consumer accepts the head vector.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored vectors.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: FIFO status flags.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag indicating a vector was dropped.
REQ-013 The block SHALL have port clr_max, input, 1 bit: restarts per-lane maximum tracking.
REQ-014 The block SHALL have port max_vect_flat, output, N*16 bits: per-lane running FP16 maximum.

Function
REQ-015 The block SHALL be a first-word-fall-through FIFO: out_tvalid = !empty, and out_vect_flat = the stored head entry, or all zeros when empty.
REQ-016 A pop SHALL occur on a rising edge when out_tvalid && out_tready; the read pointer then advances modulo DEPTH.
REQ-017 A write SHALL occur on a rising edge when in_tvalid && (!full || pop that edge); the write pointer then advances modulo DEPTH.
REQ-018 A vector written at edge k SHALL be visible on out_vect_flat, with out_tvalid=1, in the cycle after edge k (1-cycle latency when the FIFO was empty).
REQ-019 A simultaneous write and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered-consistent with count.
REQ-021 When in_tvalid=1, full=1 and no pop occurs, the vector SHALL be discarded, FIFO contents SHALL be unchanged, and overflow SHALL be set to 1 until rst.
REQ-022 out_tready while empty SHALL have no effect.
REQ-023 On each accepted write, lane i of the running maximum SHALL become max(current, incoming) under FP16 ordering: sign-magnitude compare, with +0 ranked above -0.
REQ-024 An incoming NaN lane (exponent 5'h1F with nonzero mantissa) SHALL leave that lane's maximum unchanged.
REQ-025 clr_max=1 SHALL set every lane's maximum to 16'hFC00 (-inf) at the edge; if a write occurs on the same edge, the lane SHALL take the incoming value instead, or -inf if the incoming value is NaN.
REQ-026 Dropped (overflow) vectors SHALL NOT update the maximum.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL clear both pointers and count to 0, set empty=1, full=0, overflow=0, out_tvalid=0, out_vect_flat=0 and every max_vect_flat lane to 16'hFC00.
REQ-028 rst SHALL override any write, pop or clr_max on the same edge; in-flight contents are lost, and storage RAM contents need not be cleared.

Configuration
REQ-029 With macro VFU_RESULT_BUFFER_MAX_TRACK_EN defined, the block SHALL implement the maximum tracking in REQ-023 through REQ-026.
REQ-030 Without VFU_RESULT_BUFFER_MAX_TRACK_EN, the max_vect_flat and clr_max ports SHALL remain present, every max_vect_flat lane SHALL be constant 16'hFC00, clr_max SHALL be ignored, and no compare logic SHALL be synthesized.

Verification
REQ-031 The bench SHALL cover single vector: after reset, write {4000,3E00,3C00,3800} with out_tready=0 -> next cycle out_tvalid=1, out_vect_flat={4000,3E00,3C00,3800}, count=1.
REQ-032 The bench SHALL cover fill and overflow: 9 consecutive writes with DEPTH=8 and out_tready=0 -> full=1, count=8, overflow=1; the 9th vector is never output, and 8 pops return vectors 1-8 in order.
REQ-033 The bench SHALL cover full with simultaneous write and pop: with count=8, drive in_tvalid=1 and out_tready=1 -> count stays 8, overflow stays 0, and the new vector is output after the 7 remaining ones.
REQ-034 The bench SHALL cover maximum tracking (macro on): lane 0 writes 3800, C400, 7E00(NaN), 3C00 -> max lane 0 = 3C00; writing 8000 then 0000 to a cleared lane -> 0000.
REQ-035 The bench SHALL cover clr_max with a same-edge write of 4200 in all lanes -> max_vect_flat = 4200 in all lanes; clr_max alone -> FC00 in all lanes.
REQ-036 The bench SHALL cover reset mid-operation: rst=1 with count=5 and a write pending -> next cycle count=0, empty=1, out_tvalid=0, overflow=0, max=FC00.
